// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared defaults for the image front end and the read-side
//                state encoding of the ping-pong image buffer.
//  Contents    : PIX_W / IMG_SIZE / IMGS_PER_BANK / REPLAY_W defaults,
//                read FSM state codes, clog2 helper clamped to >= 1.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int PIX_W_DEF         = 12;
    localparam int IMG_SIZE_DEF      = 784;
    localparam int IMGS_PER_BANK_DEF = 3;
    localparam int REPLAY_W_DEF      = 4;

    typedef logic [1:0] rd_state_t;

    localparam logic [1:0] RD_IDLE   = 2'd0;
    localparam logic [1:0] RD_STREAM = 2'd1;
    localparam logic [1:0] RD_DRAIN  = 2'd2;

    // Width needed to index n items, never narrower than one bit so that
    // degenerate sizes still give legal vector declarations.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : nn_pkg
`default_nettype wire

// File: rtl/pp_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : pp_bank_ram
//  Description : Simple dual-port RAM, one write port and one synchronous
//                read port, written so that it maps onto block RAM.
//  Ports       : clk_i            clock
//                we_i/waddr_i/wdata_i   write port
//                re_i/raddr_i           read request
//                rdata_o                read data, valid the cycle after re_i
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_bank_ram
    import nn_pkg::*;
#(
    parameter int DATA_W = PIX_W_DEF,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [WORDS];

    // No reset on the array or the read register: keeps it a plain BRAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule : pp_bank_ram
`default_nettype wire

// File: rtl/image_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : image_pingpong_buffer
//  Description : Double-banked image buffer. One bank fills from the DMA
//                stream while the other, already full, streams to layer 0,
//                optionally several times (replay) before being released.
//  Ports       : CLK, RST        clock, async active-high reset
//                s_t*            input stream (data/valid/ready)
//                m_t*            output stream (data/valid/ready/last)
//                m_img_idx       image number within the bank being streamed
//                replay_cnt      passes per bank (0 means 1)
//                flush           synchronous soft clear
//                bank_full       per-bank full flags
//                images_out      images streamed incl. replays, mod 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
module image_pingpong_buffer
    import nn_pkg::*;
#(
    parameter  int PIX_W         = PIX_W_DEF,
    parameter  int IMG_SIZE      = IMG_SIZE_DEF,
    parameter  int IMGS_PER_BANK = IMGS_PER_BANK_DEF,
    parameter  int REPLAY_W      = REPLAY_W_DEF,
    localparam int IDX_W         = clog2_min1(IMGS_PER_BANK)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [PIX_W-1:0]    s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [PIX_W-1:0]    m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [IDX_W-1:0]    m_img_idx,
    input  logic [REPLAY_W-1:0] replay_cnt,
    input  logic                flush,
    output logic [1:0]          bank_full,
    output logic [15:0]         images_out
);

    localparam int DEPTH = IMG_SIZE * IMGS_PER_BANK;
    localparam int AW    = clog2_min1(DEPTH);
    localparam int OFF_W = clog2_min1(IMG_SIZE);

    localparam logic [AW-1:0]    PTR_LAST = AW'(DEPTH - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(IMG_SIZE - 1);
    localparam logic [IDX_W-1:0] IMG_LAST = IDX_W'(IMGS_PER_BANK - 1);

    // ------------------------------------------------------------------ state
    logic                ready_en_q;
    logic [1:0]          bank_full_q, bank_full_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [IDX_W-1:0]    img_q, img_d;
    logic [REPLAY_W-1:0] pass_q, pass_d;
    rd_state_t           state_q, state_d;
    logic [15:0]         images_q;

    // Read pipeline stage: sideband that matches the word inside the RAM.
    logic                rd_vld_q;
    logic                rd_last_q;
    logic [IDX_W-1:0]    rd_idx_q;
    logic [PIX_W-1:0]    ram_rdata;

    // Two-entry output skid FIFO.
    logic [PIX_W-1:0]    sk_data_q [2];
    logic                sk_last_q [2];
    logic [IDX_W-1:0]    sk_idx_q  [2];
    logic                sk_head_q;
    logic [1:0]          sk_cnt_q;

    // ------------------------------------------------------------ comb wires
    logic                w_wr_fire, w_fill_done, w_pop, w_space;
    logic [2:0]          w_occ;
    logic                w_go, w_issue, w_release;
    logic [AW-1:0]       w_cur_ptr;
    logic [REPLAY_W-1:0] w_cur_pass, w_pass_dec;
    logic [OFF_W-1:0]    w_cur_off;
    logic [IDX_W-1:0]    w_cur_img;
    logic                w_tail;

    assign s_tready   = ready_en_q && !bank_full_q[wr_bank_q];
    assign w_wr_fire  = s_tvalid && s_tready;

    assign m_tvalid   = (sk_cnt_q != 2'd0);
    assign m_tdata    = sk_data_q[sk_head_q];
    assign m_tlast    = m_tvalid && sk_last_q[sk_head_q];
    assign m_img_idx  = sk_idx_q[sk_head_q];
    assign bank_full  = bank_full_q;
    assign images_out = images_q;

    assign w_pop  = m_tvalid && m_tready;
    // A read issued now lands in the skid two edges later; allow it only if
    // the skid plus the word already in the RAM stage, minus this cycle's
    // pop, leaves a free slot even if nothing is popped next cycle.
    assign w_occ   = {1'b0, sk_cnt_q} + {2'b00, rd_vld_q} - {2'b00, w_pop};
    assign w_space = (w_occ <= 3'd1);
    assign w_tail  = sk_head_q ^ sk_cnt_q[0];

    // ------------------------------------------------------------ write side
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_bank_d   = wr_bank_q;
        w_fill_done = 1'b0;
        if (w_wr_fire) begin
            if (wr_ptr_q == PTR_LAST) begin
                wr_ptr_d    = '0;
                wr_bank_d   = ~wr_bank_q;
                w_fill_done = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
        end
    end

    // -------------------------------------------------------------- read FSM
    // IDLE issues the first read itself (address 0, fresh pass count) so
    // the first word appears two edges after the bank becomes full.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        pass_d     = pass_q;
        off_d      = off_q;
        img_d      = img_q;
        rd_bank_d  = rd_bank_q;
        w_go       = 1'b0;
        w_issue    = 1'b0;
        w_release  = 1'b0;
        w_cur_ptr  = rd_ptr_q;
        w_cur_pass = pass_q;
        w_cur_off  = off_q;
        w_cur_img  = img_q;
        w_pass_dec = pass_q;

        case (state_q)
            RD_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    w_go       = 1'b1;
                    w_cur_ptr  = '0;
                    w_cur_pass = (replay_cnt == '0) ? REPLAY_W'(1) : replay_cnt;
                    w_cur_off  = '0;
                    w_cur_img  = '0;
                end
            end
            RD_STREAM: begin
                w_go = 1'b1;
            end
            RD_DRAIN: begin
                // Final word is the only one left and is leaving now.
                if (w_pop && (sk_cnt_q == 2'd1) && !rd_vld_q) begin
                    w_release = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = RD_IDLE;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        if (w_go && w_space) begin
            w_issue    = 1'b1;
            w_pass_dec = w_cur_pass - REPLAY_W'(1);

            if (w_cur_off == OFF_LAST) begin
                off_d = '0;
                img_d = (w_cur_img == IMG_LAST) ? '0 : w_cur_img + IDX_W'(1);
            end else begin
                off_d = w_cur_off + OFF_W'(1);
                img_d = w_cur_img;
            end

            if (w_cur_ptr == PTR_LAST) begin
                rd_ptr_d = '0;
                if (w_pass_dec != '0) begin
                    pass_d  = w_pass_dec;
                    state_d = RD_STREAM;
                end else begin
                    pass_d  = '0;
                    state_d = RD_DRAIN;
                end
            end else begin
                rd_ptr_d = w_cur_ptr + AW'(1);
                pass_d   = w_cur_pass;
                state_d  = RD_STREAM;
            end
        end
    end

    // The filling bank and the releasing bank are always different banks,
    // so both updates can land in the same cycle.
    always_comb begin
        bank_full_d = bank_full_q;
        if (w_fill_done) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
        if (w_release) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    // ---------------------------------------------------------------- memory
    pp_bank_ram #(
        .DATA_W (PIX_W),
        .ADDR_W (AW + 1)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (w_wr_fire && !flush),
        .waddr_i ({wr_bank_q, wr_ptr_q}),
        .wdata_i (s_tdata),
        .re_i    (w_issue && !flush),
        .raddr_i ({rd_bank_q, w_cur_ptr}),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------- registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ready_en_q  <= 1'b0;
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            off_q       <= '0;
            img_q       <= '0;
            pass_q      <= '0;
            state_q     <= RD_IDLE;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_idx_q    <= '0;
            images_q    <= '0;
        end else if (flush) begin
            ready_en_q  <= 1'b1;
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            off_q       <= '0;
            img_q       <= '0;
            pass_q      <= '0;
            state_q     <= RD_IDLE;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_idx_q    <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            off_q       <= off_d;
            img_q       <= img_d;
            pass_q      <= pass_d;
            state_q     <= state_d;
            rd_vld_q    <= w_issue;
            rd_last_q   <= (w_cur_off == OFF_LAST);
            rd_idx_q    <= w_cur_img;
            if (w_pop && m_tlast) begin
                images_q <= images_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                sk_data_q[i] <= '0;
                sk_last_q[i] <= 1'b0;
                sk_idx_q[i]  <= '0;
            end
            sk_head_q <= 1'b0;
            sk_cnt_q  <= 2'd0;
        end else if (flush) begin
            for (int i = 0; i < 2; i++) begin
                sk_data_q[i] <= '0;
                sk_last_q[i] <= 1'b0;
                sk_idx_q[i]  <= '0;
            end
            sk_head_q <= 1'b0;
            sk_cnt_q  <= 2'd0;
        end else begin
            if (rd_vld_q) begin
                sk_data_q[w_tail] <= ram_rdata;
                sk_last_q[w_tail] <= rd_last_q;
                sk_idx_q[w_tail]  <= rd_idx_q;
            end
            if (w_pop) begin
                sk_head_q <= ~sk_head_q;
            end
            sk_cnt_q <= sk_cnt_q + {1'b0, rd_vld_q} - {1'b0, w_pop};
        end
    end

endmodule : image_pingpong_buffer
`default_nettype wire

// File: tb/tb_image_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_pingpong_buffer
//  Description : Self-checking bench for image_pingpong_buffer with
//                IMG_SIZE=4, IMGS_PER_BANK=2 (DEPTH=8). Accepted input words
//                build a model bank; each completed bank pushes its expected
//                output (times the replay count) onto a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_pingpong_buffer;

    localparam int PIX_W    = 12;
    localparam int IMG_SIZE = 4;
    localparam int IMGS     = 2;
    localparam int REPLAY_W = 4;
    localparam int DEPTH    = IMG_SIZE * IMGS;

    typedef struct packed {
        logic [PIX_W-1:0] d;
        logic             l;
        logic [0:0]       i;
    } exp_t;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [PIX_W-1:0]    s_tdata = '0;
    logic                s_tvalid = 1'b0;
    logic                s_tready;
    logic [PIX_W-1:0]    m_tdata;
    logic                m_tvalid;
    logic                m_tready = 1'b1;
    logic                m_tlast;
    logic [0:0]          m_img_idx;
    logic [REPLAY_W-1:0] replay_cnt = 4'd1;
    logic                flush = 1'b0;
    logic [1:0]          bank_full;
    logic [15:0]         images_out;

    image_pingpong_buffer #(
        .PIX_W         (PIX_W),
        .IMG_SIZE      (IMG_SIZE),
        .IMGS_PER_BANK (IMGS),
        .REPLAY_W      (REPLAY_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_img_idx  (m_img_idx),
        .replay_cnt (replay_cnt),
        .flush      (flush),
        .bank_full  (bank_full),
        .images_out (images_out)
    );

    always #5 CLK = ~CLK;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_written = 0;
    int               n_out = 0;
    int               exp_images = 0;
    bit               mon_en = 1'b0;
    exp_t             exp_q[$];
    logic [PIX_W-1:0] fill_q[$];
    exp_t             mon_e;
    int               mon_passes;
    bit               hold_q = 1'b0;
    logic [PIX_W-1:0] hold_data;

    // Scoreboard monitor, sampling mid-cycle on the falling edge.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (s_tvalid && s_tready) begin
                fill_q.push_back(s_tdata);
                n_written++;
                if (fill_q.size() == DEPTH) begin
                    mon_passes = (replay_cnt == 0) ? 1 : int'(replay_cnt);
                    for (int p = 0; p < mon_passes; p++) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            mon_e.d = fill_q[k];
                            mon_e.l = ((k % IMG_SIZE) == IMG_SIZE - 1);
                            mon_e.i = 1'(k / IMG_SIZE);
                            exp_q.push_back(mon_e);
                        end
                    end
                    fill_q.delete();
                end
            end
            if (hold_q) begin
                n_cmp++;
                if (!m_tvalid || m_tdata !== hold_data) begin
                    n_bad++;
                    $display("FAIL hold_stable: got valid=%0b data=%0d, need valid=1 data=%0d",
                             m_tvalid, m_tdata, hold_data);
                end
            end
            if (m_tvalid && m_tready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_word: got data=%0d, none expected", m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_tdata, m_tlast, m_img_idx} !== {mon_e.d, mon_e.l, mon_e.i}) begin
                        n_bad++;
                        $display("FAIL out_word: got d=%0d last=%0b idx=%0d, need d=%0d last=%0b idx=%0d",
                                 m_tdata, m_tlast, m_img_idx, mon_e.d, mon_e.l, mon_e.i);
                    end
                    if (mon_e.l) exp_images++;
                end
                n_out++;
            end
            hold_q    = m_tvalid && !m_tready;
            hold_data = m_tdata;
        end else begin
            hold_q = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [PIX_W-1:0] d);
        bit ok = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (s_tready) begin
                ok = 1'b1;
                @(posedge CLK); #1;
                break;
            end
            @(posedge CLK); #1;
        end
        s_tvalid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: word %0d not accepted, s_tready=%0b", d, s_tready);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK); #1;
            if (exp_q.size() == 0 && fill_q.size() == 0 && !m_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d words still expected, m_tvalid=%0b",
                     exp_q.size(), m_tvalid);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({s_tready, m_tvalid, m_tlast, m_tdata, m_img_idx, bank_full, images_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: got rdy=%0b vld=%0b last=%0b d=%0d idx=%0d full=%b img=%0d, need all 0",
                     s_tready, m_tvalid, m_tlast, m_tdata, m_img_idx, bank_full, images_out);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        mon_en = 1'b1;
        @(posedge CLK); #1;
        n_cmp++;
        if (s_tready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %0b need 1", s_tready);
        end
    endtask

    task automatic test_basic();
        m_tready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) send(PIX_W'(i));
        n_cmp++;
        if (bank_full !== 2'b01) begin
            n_bad++;
            $display("FAIL basic_full: got %b need 01", bank_full);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (m_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_lat1: m_tvalid got %0b need 0", m_tvalid);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (m_tvalid !== 1'b1 || m_tdata !== 12'd1) begin
            n_bad++;
            $display("FAIL basic_lat2: got vld=%0b d=%0d need vld=1 d=1", m_tvalid, m_tdata);
        end
        wait_drain();
        n_cmp++;
        if (images_out !== 16'd2 || bank_full !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_end: got img=%0d full=%b need img=2 full=00", images_out, bank_full);
        end
    endtask

    task automatic test_backpressure();
        int base = n_written;
        m_tready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 24; i++) send(PIX_W'(i));
            end
            begin
                repeat (30) @(posedge CLK);
                #1;
                n_cmp++;
                if (s_tready !== 1'b0 || bank_full !== 2'b11 || n_written - base != 16) begin
                    n_bad++;
                    $display("FAIL bp_stall: got rdy=%0b full=%b written=%0d need rdy=0 full=11 written=16",
                             s_tready, bank_full, n_written - base);
                end
                m_tready = 1'b1;
            end
        join
        wait_drain();
        n_cmp++;
        if (n_written - base != 24 || images_out !== 16'(exp_images)) begin
            n_bad++;
            $display("FAIL bp_end: got written=%0d img=%0d need written=24 img=%0d",
                     n_written - base, images_out, exp_images);
        end
    endtask

    task automatic test_replay();
        int  img0 = exp_images;
        int  bubbles = 0;
        bit  seen = 1'b0;
        replay_cnt = 4'd3;
        m_tready   = 1'b1;
        for (int i = 1; i <= DEPTH; i++) send(PIX_W'(i));
        for (int i = 0; i < 20; i++) begin
            if (m_tvalid) begin seen = 1'b1; break; end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL replay_start: m_tvalid got 0 need 1");
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (!m_tvalid) bubbles++;
            if (i == 3 * DEPTH - 2) begin
                n_cmp++;
                if (bank_full === 2'b00) begin
                    n_bad++;
                    $display("FAIL replay_early_release: got full=%b need nonzero", bank_full);
                end
            end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if (bubbles != 0) begin
            n_bad++;
            $display("FAIL replay_bubbles: got %0d need 0", bubbles);
        end
        wait_drain();
        n_cmp++;
        if (images_out !== 16'(img0 + 6) || bank_full !== 2'b00) begin
            n_bad++;
            $display("FAIL replay_end: got img=%0d full=%b need img=%0d full=00",
                     images_out, bank_full, img0 + 6);
        end
        replay_cnt = 4'd1;
    endtask

    task automatic test_random();
        bit sent = 1'b0;
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) send(PIX_W'($urandom_range(0, 4095)));
                sent = 1'b1;
            end
            begin
                for (int c = 0; c < 3000; c++) begin
                    @(posedge CLK); #1;
                    m_tready = 1'($urandom_range(0, 1));
                    if (sent && exp_q.size() == 0 && fill_q.size() == 0) begin
                        done = 1'b1;
                        break;
                    end
                end
            end
        join
        m_tready = 1'b1;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL random_timeout: %0d words outstanding need 0", exp_q.size());
        end
        wait_drain();
    endtask

    task automatic test_flush();
        int  pre;
        bit  seen = 1'b0;
        m_tready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) send(PIX_W'(i));
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (m_tvalid && m_tdata == 12'd5) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL flush_word5: word 5 never presented");
        end
        pre    = exp_images;
        mon_en = 1'b0;
        flush  = 1'b1;
        @(posedge CLK); #1;
        flush  = 1'b0;
        n_cmp++;
        if (m_tvalid !== 1'b0 || bank_full !== 2'b00 || images_out !== 16'(pre)) begin
            n_bad++;
            $display("FAIL flush_clear: got vld=%0b full=%b img=%0d need vld=0 full=00 img=%0d",
                     m_tvalid, bank_full, images_out, pre);
        end
        exp_q.delete();
        fill_q.delete();
        mon_en = 1'b1;
        for (int i = 9; i <= 16; i++) send(PIX_W'(i));
        n_cmp++;
        if (bank_full !== 2'b01) begin
            n_bad++;
            $display("FAIL flush_refill_bank: got %b need 01", bank_full);
        end
        wait_drain();
        n_cmp++;
        if (images_out !== 16'(pre + 2)) begin
            n_bad++;
            $display("FAIL flush_images: got %0d need %0d", images_out, pre + 2);
        end
    endtask

    task automatic test_rst();
        m_tready = 1'b1;
        for (int i = 1; i <= 3; i++) send(PIX_W'(i));
        s_tdata  = 12'd4;
        s_tvalid = 1'b1;
        #2;
        mon_en = 1'b0;
        RST    = 1'b1;
        #1;
        n_cmp++;
        if ({s_tready, m_tvalid, m_tlast, m_tdata, m_img_idx, bank_full, images_out} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%0b vld=%0b full=%b img=%0d need all 0",
                     s_tready, m_tvalid, bank_full, images_out);
        end
        s_tvalid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        fill_q.delete();
        exp_images = 0;
        mon_en = 1'b1;
        @(posedge CLK); #1;
        for (int i = 1; i <= DEPTH; i++) send(PIX_W'(i + 40));
        wait_drain();
        n_cmp++;
        if (images_out !== 16'd2 || bank_full !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_resume: got img=%0d full=%b need img=2 full=00", images_out, bank_full);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_replay();
        test_random();
        test_flush();
        test_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_image_pingpong_buffer
`default_nettype wire
